uart_rx_os: RTL and testbench

UART_RX_OS -- requirements
Module: uart_rx_os

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 33 +++
 rtl/uart_rx_os.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared state type, defaults and tick-divider helper for the oversampling UART receiver.
// Build option: define UART_RX_PARITY_EN to add the parity state.
package uart_pkg;

  localparam int unsigned DefBaudRate   = 9600;
  localparam int unsigned DefClockHz    = 50_000_000;
  localparam int unsigned DefOversample = 16;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} rx_state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} rx_state_e;
`endif

  function automatic int unsigned tick_div(input int unsigned clock_hz,
                                           input int unsigned baud_rate,
                                           input int unsigned oversample);
    int unsigned div;
    div = clock_hz / (baud_rate * oversample);
    return (div == 0) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every CLOCK_HZ/(BAUD_RATE*OVERSAMPLE) clocks,
// restarted by clear.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_HZ   = DefClockHz,
  parameter int unsigned BAUD_RATE  = DefBaudRate,
  parameter int unsigned OVERSAMPLE = DefOversample
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned Div  = tick_div(CLOCK_HZ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CntMax);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    if (clear) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 3-sample majority vote, valid/ready output and error pulses.
// Build option: UART_RX_PARITY_EN adds a checked parity bit after the data bits.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_RATE  = DefBaudRate,
  parameter int unsigned CLOCK_HZ   = DefClockHz,
  parameter int unsigned N_BITS     = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = DefOversample,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rxd,
  output logic [N_BITS-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              finished,
  output logic              framing_err,
  output logic              parity_err,
  output logic              overrun_err,
  output logic              busy
);

  localparam int unsigned OsW  = $clog2(OVERSAMPLE);
  localparam int unsigned BitW = $clog2(N_BITS);
  localparam logic [OsW-1:0]  OsMax    = OsW'(OVERSAMPLE - 1);
  localparam logic [OsW-1:0]  SmpA     = OsW'(OVERSAMPLE / 2 - 1);
  localparam logic [OsW-1:0]  SmpB     = OsW'(OVERSAMPLE / 2);
  localparam logic [OsW-1:0]  SmpC     = OsW'(OVERSAMPLE / 2 + 1);
  localparam logic [BitW-1:0] BitLast  = BitW'(N_BITS - 1);
  localparam logic [BitW-1:0] StopLast = BitW'(STOP_BITS - 1);

  rx_state_e         state_q, state_d;
  logic              sync1_q, sync2_q, rx_s;
  logic [1:0]        warm_q;
  logic              prev_q;
  logic [OsW-1:0]    os_q, os_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [1:0]        samp_q, samp_d;
  logic [N_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic              fe_q, fe_d, valid_q, valid_d;
  logic              finished_q, finished_d, fe_out_q, fe_out_d, oe_q, oe_d;
  logic              tick, tick_clear;
  logic              at_mid, bit_end, maj, done;
`ifdef UART_RX_PARITY_EN
  localparam logic ParOdd = (PARITY_ODD != 0);
  logic pe_q, pe_d, pe_out_q, pe_out_d;
`endif

  uart_baud_tick #(
    .CLOCK_HZ  (CLOCK_HZ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (tick_clear),
    .tick   (tick)
  );

  assign rx_s = sync2_q;

  always_comb begin
    state_d    = state_q;
    os_d       = os_q;
    bit_d      = bit_q;
    samp_d     = samp_q;
    shift_d    = shift_q;
    fe_d       = fe_q;
    data_d     = data_q;
    valid_d    = valid_q;
    finished_d = 1'b0;
    fe_out_d   = 1'b0;
    oe_d       = 1'b0;
    tick_clear = 1'b0;
    done       = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe_d     = pe_q;
    pe_out_d = 1'b0;
`endif
    at_mid  = tick && (os_q == SmpC);
    bit_end = tick && (os_q == OsMax);
    // samp_q holds the first two votes; the third is the live line value
    maj     = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s) | (samp_q[0] & rx_s);

    if (valid_q && ready) valid_d = 1'b0;

    if (tick && (state_q != StIdle)) begin
      os_d = (os_q == OsMax) ? '0 : os_q + 1'b1;
      if ((os_q == SmpA) || (os_q == SmpB)) samp_d = {samp_q[0], rx_s};
    end

    unique case (state_q)
      StIdle: begin
        if (prev_q && !rx_s) begin
          state_d    = StStart;
          tick_clear = 1'b1;
          os_d       = '0;
          bit_d      = '0;
          fe_d       = 1'b0;
`ifdef UART_RX_PARITY_EN
          pe_d       = 1'b0;
`endif
        end
      end
      StStart: begin
        if (at_mid && maj) state_d = StIdle;
        else if (bit_end)  state_d = StData;
      end
      StData: begin
        if (at_mid) shift_d = {maj, shift_q[N_BITS-1:1]};
        if (bit_end) begin
          if (bit_q == BitLast) begin
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (at_mid)  pe_d = ((^shift_q) ^ maj) != ParOdd;
        if (bit_end) state_d = StStop;
      end
`endif
      StStop: begin
        // Leave at mid final stop bit so a start edge right after it is caught
        if (at_mid) begin
          if (bit_q == StopLast) begin
            done    = 1'b1;
            state_d = StIdle;
          end else begin
            fe_d = fe_q | ~maj;
          end
        end
        if (bit_end) bit_d = bit_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (done) begin
      finished_d = 1'b1;
      fe_out_d   = fe_q | ~maj;
`ifdef UART_RX_PARITY_EN
      pe_out_d   = pe_q;
`endif
      if (!valid_q || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        oe_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      warm_q     <= '0;
      prev_q     <= 1'b0;
      os_q       <= '0;
      bit_q      <= '0;
      samp_q     <= '0;
      shift_q    <= '0;
      fe_q       <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      finished_q <= 1'b0;
      fe_out_q   <= 1'b0;
      oe_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_q       <= 1'b0;
      pe_out_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sync1_q    <= rxd;
      sync2_q    <= sync1_q;
      warm_q     <= {warm_q[0], 1'b1};
      // The synchroniser's reset value must not count as having seen the line high
      prev_q     <= warm_q[1] ? rx_s : 1'b0;
      os_q       <= os_d;
      bit_q      <= bit_d;
      samp_q     <= samp_d;
      shift_q    <= shift_d;
      fe_q       <= fe_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      finished_q <= finished_d;
      fe_out_q   <= fe_out_d;
      oe_q       <= oe_d;
`ifdef UART_RX_PARITY_EN
      pe_q       <= pe_d;
      pe_out_q   <= pe_out_d;
`endif
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign finished    = finished_q;
  assign framing_err = fe_out_q;
  assign overrun_err = oe_q;
  assign busy        = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
  assign parity_err  = pe_out_q;
`else
  assign parity_err  = 1'b0;
  logic unused_parity;
  assign unused_parity = ^PARITY_ODD;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: vector table plus hand-written corner sequences.
module tb_uart_rx_os;

  localparam int unsigned ClkHz    = 1_600_000;
  localparam int unsigned Baud     = 12_500;
  localparam int unsigned Os       = 16;
  localparam int unsigned NBits    = 8;
  localparam int unsigned StopBits = 1;
  localparam int unsigned ParOdd   = 0;
  localparam int unsigned Div      = ClkHz / (Baud * Os);
  localparam int unsigned Bit      = Div * Os;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned ParBits = 1;
`else
  localparam int unsigned ParBits = 0;
`endif
  localparam int unsigned FinalStop = NBits + ParBits + StopBits;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rxd = 1'b1;
  logic ready = 1'b1;
  logic [NBits-1:0] data;
  logic valid, finished, framing_err, parity_err, overrun_err, busy;

  uart_rx_os #(
    .BAUD_RATE (Baud),
    .CLOCK_HZ  (ClkHz),
    .N_BITS    (NBits),
    .STOP_BITS (StopBits),
    .OVERSAMPLE(Os),
    .PARITY_ODD(ParOdd)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rxd        (rxd),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .finished   (finished),
    .framing_err(framing_err),
    .parity_err (parity_err),
    .overrun_err(overrun_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_fin = 0, n_vcyc = 0, n_oe = 0, n_busy = 0, n_stray = 0;
  logic [NBits-1:0] last_d = '0;
  logic last_fe = 1'b0, last_pe = 1'b0, last_oe = 1'b0;
  int unsigned fin_cyc = 0;

  always @(negedge clk) begin
    if (finished) begin
      n_fin++;
      last_d  = data;
      last_fe = framing_err;
      last_pe = parity_err;
      last_oe = overrun_err;
      fin_cyc = cyc;
    end
    if (valid) n_vcyc++;
    if (overrun_err) n_oe++;
    if (busy) n_busy++;
    if ((framing_err || parity_err || overrun_err) && !finished) n_stray++;
  end

  typedef struct {
    logic [NBits-1:0] d;
    logic             par_v;
    logic             stop_v;
    bit               spike;
    logic [NBits-1:0] exp_d;
    logic             exp_fe;
    logic             exp_pe;
  } vec_t;

  // Reference: word as sent, framing from stop level, parity from data+parity bit count
  function automatic vec_t mk(input logic [NBits-1:0] d, input logic par_v,
                              input logic stop_v, input bit spike);
    vec_t v;
    logic odd;
    odd      = (ParOdd != 0);
    v.d      = d;
    v.par_v  = par_v;
    v.stop_v = stop_v;
    v.spike  = spike;
    v.exp_d  = d;
    v.exp_fe = ~stop_v;
    v.exp_pe = (ParBits != 0) ? ((^d) ^ par_v ^ odd) : 1'b0;
    return v;
  endfunction

  int total = 0, bad = 0;
  int s_fin, s_vcyc, s_oe, s_busy;
  int unsigned fstart;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic snap();
    s_fin  = n_fin;
    s_vcyc = n_vcyc;
    s_oe   = n_oe;
    s_busy = n_busy;
  endtask

  task automatic drive_bit(input logic lvl, input int spike_at);
    for (int c = 0; c < int'(Bit); c++) begin
      rxd = (c == spike_at) ? ~lvl : lvl;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input vec_t v);
    int sp;
    fstart = cyc;
    drive_bit(1'b0, -1);
    for (int i = 0; i < int'(NBits); i++) begin
      // Invert the line for one clock at one of the three vote points of the bit
      sp = v.spike ? int'((Os / 2 + $urandom_range(0, 2)) * Div) : -1;
      drive_bit(v.d[i], sp);
    end
    if (ParBits != 0) drive_bit(v.par_v, -1);
    for (int s = 0; s < int'(StopBits); s++) drive_bit(v.stop_v, -1);
    drive_bit(1'b1, -1);
  endtask

  task automatic check_outputs_low(input string tag);
    check({tag, " data"}, 32'(data), 32'h0);
    check({tag, " valid"}, 32'(valid), 32'h0);
    check({tag, " finished"}, 32'(finished), 32'h0);
    check({tag, " errs"}, {29'h0, framing_err, parity_err, overrun_err}, 32'h0);
    check({tag, " busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    vec_t v;
    int unsigned dt;

    vecs.push_back(mk(8'h56, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(8'h56, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(8'h56, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(8'h56, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(8'h00, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(8'hFF, 1'b0, 1'b1, 1'b1));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(NBits'($urandom), 1'($urandom), 1'b1, ($urandom % 2) == 1));

    // Reset with the line held low; no start may be seen until it has gone high
    reset_n = 1'b0;
    rxd     = 1'b0;
    ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_low("reset");
    reset_n = 1'b1;
    snap();
    repeat (2 * Bit) @(posedge clk);
    #1;
    check("low line after reset busy cycles", 32'(n_busy - s_busy), 32'h0);
    rxd = 1'b1;
    repeat (Bit) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      v = vecs[i];
      snap();
      send_frame(v);
      dt = fin_cyc - fstart;
      check($sformatf("v%0d finished count", i), 32'(n_fin - s_fin), 32'h1);
      check($sformatf("v%0d data", i), 32'(last_d), 32'(v.exp_d));
      check($sformatf("v%0d framing_err", i), 32'(last_fe), 32'(v.exp_fe));
      check($sformatf("v%0d parity_err", i), 32'(last_pe), 32'(v.exp_pe));
      check($sformatf("v%0d overrun count", i), 32'(n_oe - s_oe), 32'h0);
      check($sformatf("v%0d valid cycles", i), 32'(n_vcyc - s_vcyc), 32'h1);
      check($sformatf("v%0d finish inside last stop bit", i),
            32'((dt >= FinalStop * Bit + (Os / 2) * Div) && (dt < (FinalStop + 1) * Bit)), 32'h1);
    end

    // Overrun: second word arrives while the first is still unread
    ready = 1'b0;
    snap();
    send_frame(mk(8'h56, 1'b0, 1'b1, 1'b0));
    send_frame(mk(8'hA3, 1'b0, 1'b1, 1'b0));
    check("overrun finished count", 32'(n_fin - s_fin), 32'h2);
    check("overrun data held", 32'(data), 32'h56);
    check("overrun data at 2nd finish", 32'(last_d), 32'h56);
    check("overrun pulse count", 32'(n_oe - s_oe), 32'h1);
    check("overrun with finished", 32'(last_oe), 32'h1);
    check("overrun valid held", 32'(valid), 32'h1);
    ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("valid cleared by ready", 32'(valid), 32'h0);

    // Short low glitch: start is detected, then rejected at the vote
    snap();
    rxd = 1'b0;
    repeat (Bit * 2000 / 5200) @(posedge clk);
    #1;
    rxd = 1'b1;
    repeat (12 * Bit) @(posedge clk);
    #1;
    check("glitch finished count", 32'(n_fin - s_fin), 32'h0);
    check("glitch start seen", 32'((n_busy - s_busy) > 0), 32'h1);
    check("glitch back to idle", 32'(busy), 32'h0);

    // Reset after the 4th data bit, then a clean frame
    snap();
    v = mk(8'hC5, 1'b0, 1'b1, 1'b0);
    drive_bit(1'b0, -1);
    for (int i = 0; i < 4; i++) drive_bit(v.d[i], -1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_outputs_low("mid-frame reset");
    reset_n = 1'b1;
    rxd     = 1'b1;
    repeat (2 * Bit) @(posedge clk);
    #1;
    send_frame(mk(8'h3C, 1'b0, 1'b1, 1'b0));
    check("post-reset finished count", 32'(n_fin - s_fin), 32'h1);
    check("post-reset data", 32'(last_d), 32'h3C);
    check("post-reset framing_err", 32'(last_fe), 32'h0);

    // Break: line low for longer than a whole frame
    snap();
    rxd = 1'b0;
    repeat ((FinalStop + 2) * Bit) @(posedge clk);
    #1;
    rxd = 1'b1;
    repeat (2 * Bit) @(posedge clk);
    #1;
    check("break finished count", 32'(n_fin - s_fin), 32'h1);
    check("break data", 32'(last_d), 32'h0);
    check("break framing_err", 32'(last_fe), 32'h1);

    check("error pulses outside finished", 32'(n_stray), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
